// File: rtl/ifq_fetch_ctrl.sv
// Fill side of the instruction fetch queue: issues line reads, tracks credits and in-flight reads, redirects.
// Latency: cache response to fifo_write_en/fifo_flush is one registered cycle.
// Backpressure: requests stall when FIFO credits or the outstanding-read budget run out.
module ifq_fetch_ctrl #(
    parameter int                    CACHE_LINE_WIDTH = 128,
    parameter int                    ADDR_WIDTH       = 32,
    parameter int                    FIFO_DEPTH       = 4,
    parameter int                    MAX_OUTSTANDING  = 2,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC         = '0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        redirect_valid,
    input  logic [ADDR_WIDTH-1:0]       redirect_target,
    input  logic                        fifo_line_pop,
    output logic                        cache_rd_req,
    output logic [ADDR_WIDTH-1:0]       cache_rd_addr,
    input  logic                        cache_rd_ack,
    input  logic                        cache_rd_valid,
    input  logic [CACHE_LINE_WIDTH-1:0] cache_rd_data,
    output logic                        fifo_write_en,
    output logic                        fifo_flush,
    output logic [CACHE_LINE_WIDTH-1:0] fifo_data,
    output logic [1:0]                  jmp_branch_bits_2_3
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 2);
    localparam int CRD_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0]      OUT_MAX   = CNT_W'(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1);
    localparam logic [CRD_W-1:0]      CRD_MAX   = CRD_W'(FIFO_DEPTH - 1);
    localparam logic [CRD_W-1:0]      CRD_FLUSH = CRD_W'(FIFO_DEPTH - 2);
    localparam logic [CRD_W-1:0]      CRD_ONE   = CRD_W'(1);
    localparam logic [ADDR_WIDTH-1:0] LINE_INC  = ADDR_WIDTH'(CACHE_LINE_WIDTH / 8);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        REDIR_ISSUE,
        REDIR_WAIT
    } state_t;

    state_t                        state_q, state_d;
    logic [ADDR_WIDTH-1:0]         fetch_pc_q, fetch_pc_d;
    logic [ADDR_WIDTH-1:0]         target_q, target_d;
    logic [CRD_W-1:0]              credits_q, credits_d;
    logic [CNT_W-1:0]              outstanding_q, outstanding_d;
    logic [CNT_W-1:0]              stale_q, stale_d;
    logic                          fifo_write_en_q, fifo_write_en_d;
    logic                          fifo_flush_q, fifo_flush_d;
    logic [CACHE_LINE_WIDTH-1:0]   fifo_data_q, fifo_data_d;
    logic [1:0]                    bits_q, bits_d;

    logic [ADDR_WIDTH-1:0]         target_line;
    logic                          redir;
    logic                          issue;
    logic                          unused_tgt_bits;

    assign target_line     = {target_q[ADDR_WIDTH-1:4], 4'b0000};
    assign unused_tgt_bits = ^target_q[1:0];

    always_comb begin
        state_d         = state_q;
        fetch_pc_d      = fetch_pc_q;
        target_d        = target_q;
        credits_d       = credits_q;
        outstanding_d   = outstanding_q;
        stale_d         = stale_q;
        fifo_write_en_d = 1'b0;
        fifo_flush_d    = 1'b0;
        fifo_data_d     = fifo_data_q;
        bits_d          = bits_q;
        cache_rd_req    = 1'b0;
        cache_rd_addr   = fetch_pc_q;
        redir           = redirect_valid && (state_q != IDLE);

        case (state_q)
            IDLE:        state_d = FETCH;
            FETCH:       cache_rd_req = (credits_q != '0) && (outstanding_q < OUT_MAX) && !redirect_valid;
            REDIR_ISSUE: begin
                cache_rd_req  = !redirect_valid;
                cache_rd_addr = target_line;
            end
            default: ;
        endcase

        issue = cache_rd_req && cache_rd_ack;

        if (issue) begin
            outstanding_d = outstanding_d + CNT_ONE;
            if (state_q == REDIR_ISSUE) begin
                fetch_pc_d = target_line + LINE_INC;
                state_d    = REDIR_WAIT;
            end else begin
                fetch_pc_d = fetch_pc_q + LINE_INC;
            end
        end

        // Credits only move in FETCH; a flush re-seeds them anyway.
        if (state_q == FETCH) begin
            if (issue) credits_d = credits_d - CRD_ONE;
            if (fifo_line_pop) credits_d = credits_d + CRD_ONE;
            if (credits_d > CRD_MAX) credits_d = CRD_MAX;
        end

        if (cache_rd_valid) begin
            outstanding_d = outstanding_d - CNT_ONE;
            if (redir) begin
                // discarded: the line belongs to the abandoned path
            end else if (stale_q != '0) begin
                stale_d = stale_q - CNT_ONE;
            end else if (state_q == REDIR_WAIT) begin
                fifo_flush_d  = 1'b1;
                fifo_data_d   = cache_rd_data;
                bits_d        = target_q[3:2];
                credits_d     = CRD_FLUSH;
                outstanding_d = '0;
                state_d       = FETCH;
            end else if (state_q == FETCH) begin
                fifo_write_en_d = 1'b1;
                fifo_data_d     = cache_rd_data;
            end
        end

        // Responses are in order, so every read still in flight after a redirect is stale.
        if (redir) begin
            target_d = redirect_target;
            stale_d  = outstanding_d;
            state_d  = REDIR_ISSUE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            fetch_pc_q      <= RESET_PC;
            target_q        <= '0;
            credits_q       <= CRD_MAX;
            outstanding_q   <= '0;
            stale_q         <= '0;
            fifo_write_en_q <= 1'b0;
            fifo_flush_q    <= 1'b0;
            fifo_data_q     <= '0;
            bits_q          <= '0;
        end else begin
            state_q         <= state_d;
            fetch_pc_q      <= fetch_pc_d;
            target_q        <= target_d;
            credits_q       <= credits_d;
            outstanding_q   <= outstanding_d;
            stale_q         <= stale_d;
            fifo_write_en_q <= fifo_write_en_d;
            fifo_flush_q    <= fifo_flush_d;
            fifo_data_q     <= fifo_data_d;
            bits_q          <= bits_d;
        end
    end

    assign fifo_write_en       = fifo_write_en_q;
    assign fifo_flush          = fifo_flush_q;
    assign fifo_data           = fifo_data_q;
    assign jmp_branch_bits_2_3 = bits_q;

endmodule

// File: tb/tb_ifq_fetch_ctrl.sv
// Directed bench for ifq_fetch_ctrl with an in-order cache model driven from the main thread.
module tb_ifq_fetch_ctrl;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         redirect_valid = 1'b0;
    logic [31:0]  redirect_target = '0;
    logic         fifo_line_pop = 1'b0;
    logic         cache_rd_ack = 1'b0;
    logic         cache_rd_valid = 1'b0;
    logic [127:0] cache_rd_data = '0;

    logic         cache_rd_req;
    logic [31:0]  cache_rd_addr;
    logic         fifo_write_en;
    logic         fifo_flush;
    logic [127:0] fifo_data;
    logic [1:0]   jmp_bits;

    logic         hi_req;
    logic [31:0]  hi_addr;
    logic         hi_wr;
    logic         hi_fl;
    logic [127:0] hi_data;
    logic [1:0]   hi_bits;

    ifq_fetch_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .fifo_line_pop(fifo_line_pop),
        .cache_rd_req(cache_rd_req), .cache_rd_addr(cache_rd_addr), .cache_rd_ack(cache_rd_ack),
        .cache_rd_valid(cache_rd_valid), .cache_rd_data(cache_rd_data),
        .fifo_write_en(fifo_write_en), .fifo_flush(fifo_flush), .fifo_data(fifo_data),
        .jmp_branch_bits_2_3(jmp_bits)
    );

    ifq_fetch_ctrl #(.RESET_PC(32'hFFFF_FFF0)) dut_hi (
        .clk(clk), .rst_n(rst_n),
        .redirect_valid(1'b0), .redirect_target(32'h0),
        .fifo_line_pop(1'b0),
        .cache_rd_req(hi_req), .cache_rd_addr(hi_addr), .cache_rd_ack(cache_rd_ack),
        .cache_rd_valid(cache_rd_valid), .cache_rd_data(cache_rd_data),
        .fifo_write_en(hi_wr), .fifo_flush(hi_fl), .fifo_data(hi_data),
        .jmp_branch_bits_2_3(hi_bits)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } rsp_t;

    rsp_t         rsp_q[$];
    logic [31:0]  req_log[$];
    logic [31:0]  hi_log[$];
    int           cyc = 0;
    bit           rsp_en = 1'b1;
    logic         req_s;
    logic [31:0]  addr_s;
    int           nwr = 0;
    int           nfl = 0;
    int           both = 0;
    logic [127:0] last_wr = '0;
    logic [127:0] last_fl = '0;
    logic [1:0]   last_bits = '0;
    int           n_vec = 0;
    int           n_miss = 0;

    function automatic logic [127:0] line_of(input logic [31:0] a);
        return {a, ~a, a ^ 32'h5A5A_5A5A, ~a ^ 32'h0F0F_0F0F};
    endfunction

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: drive cache inputs, sample requests, step the edge, sample registered outputs.
    task automatic tick();
        cache_rd_ack   = 1'b1;
        cache_rd_valid = 1'b0;
        cache_rd_data  = '0;
        if (rsp_en && rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
            cache_rd_valid = 1'b1;
            cache_rd_data  = line_of(rsp_q[0].addr);
        end
        #1;
        req_s  = cache_rd_req;
        addr_s = cache_rd_addr;
        if (cache_rd_req && cache_rd_ack) begin
            rsp_q.push_back('{addr: cache_rd_addr, due: cyc + 1});
            req_log.push_back(cache_rd_addr);
        end
        if (hi_req && cache_rd_ack && hi_log.size() < 2) hi_log.push_back(hi_addr);
        if (cache_rd_valid) void'(rsp_q.pop_front());
        @(posedge clk);
        @(negedge clk);
        cyc++;
        redirect_valid = 1'b0;
        fifo_line_pop  = 1'b0;
        if (fifo_write_en) begin nwr++; last_wr = fifo_data; end
        if (fifo_flush) begin nfl++; last_fl = fifo_data; last_bits = jmp_bits; end
        if (fifo_write_en && fifo_flush) both++;
    endtask

    task automatic redirect_tick(input logic [31:0] tgt);
        redirect_valid  = 1'b1;
        redirect_target = tgt;
        tick();
    endtask

    task automatic pop_tick();
        fifo_line_pop = 1'b1;
        tick();
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req", cache_rd_req, 1'b0);
        chk("rst_addr", cache_rd_addr, 32'h0);
        chk("rst_wr", fifo_write_en, 1'b0);
        chk("rst_flush", fifo_flush, 1'b0);
        chk("rst_data", fifo_data, 128'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // straight-line fill until credits are exhausted
        tick();
        chk("idle_no_req", req_s, 1'b0);
        repeat (7) tick();
        chk("t1_nreq", req_log.size(), 3);
        chk("t1_req0", req_log[0], 32'h00);
        chk("t1_req1", req_log[1], 32'h10);
        chk("t1_req2", req_log[2], 32'h20);
        chk("t1_nwr", nwr, 3);
        chk("t1_lastwr", last_wr, line_of(32'h20));
        chk("t1_stall", req_s, 1'b0);
        chk("hi_n", hi_log.size() >= 2, 1'b1);
        chk("hi_req0", hi_log[0], 32'hFFFF_FFF0);
        chk("hi_req1", hi_log[1], 32'h0000_0000);

        // one pop frees one slot
        pop_tick();
        chk("t2_pop_cycle_req", req_s, 1'b0);
        tick();
        chk("t2_req", req_s, 1'b1);
        chk("t2_addr", addr_s, 32'h30);
        repeat (2) tick();
        chk("t2_nwr", nwr, 4);
        chk("t2_lastwr", last_wr, line_of(32'h30));

        // redirect with two reads in flight
        rsp_en = 1'b0;
        pop_tick();
        pop_tick();
        tick();
        chk("t3_req50", req_log[req_log.size()-1], 32'h50);
        rsp_en = 1'b1;
        redirect_tick(32'h1238);
        chk("t3_redir_noreq", req_s, 1'b0);
        tick();
        chk("t3_tgt_req", req_s, 1'b1);
        chk("t3_tgt_addr", addr_s, 32'h1230);
        chk("t3_noflush_yet", nfl, 0);
        tick();
        chk("t3_nfl", nfl, 1);
        chk("t3_flush_line", last_fl, line_of(32'h1230));
        chk("t3_bits", last_bits, 2'b10);
        chk("t3_stale_dropped", nwr, 4);
        tick();
        chk("t3_next_addr", addr_s, 32'h1240);
        tick();
        chk("t3_next2_addr", addr_s, 32'h1250);
        tick();
        chk("t3_credit_stall", req_s, 1'b0);
        repeat (2) tick();
        chk("t3_nwr", nwr, 6);

        // second redirect while waiting for the first target
        rsp_en = 1'b0;
        redirect_tick(32'h1238);
        tick();
        chk("t4_req1230", addr_s, 32'h1230);
        redirect_tick(32'h2004);
        rsp_en = 1'b1;
        tick();
        chk("t4_req2000", addr_s, 32'h2000);
        chk("t4_no_stale_flush", nfl, 1);
        tick();
        chk("t4_nfl", nfl, 2);
        chk("t4_flush_line", last_fl, line_of(32'h2000));
        chk("t4_bits", last_bits, 2'b01);
        chk("t4_nwr", nwr, 6);
        tick();
        chk("t4_next_addr", addr_s, 32'h2010);
        repeat (2) tick();
        chk("t4_nwr2", nwr, 8);
        chk("t4_hold_data", fifo_data, line_of(32'h2020));

        // reset while in REDIR_WAIT
        rsp_en = 1'b0;
        redirect_tick(32'h3000);
        tick();
        chk("t6_tgt_addr", addr_s, 32'h3000);
        rst_n = 1'b0;
        #1;
        chk("t6_req0", cache_rd_req, 1'b0);
        chk("t6_addr0", cache_rd_addr, 32'h0);
        chk("t6_wr0", fifo_write_en, 1'b0);
        chk("t6_fl0", fifo_flush, 1'b0);
        chk("t6_data0", fifo_data, 128'h0);
        chk("t6_bits0", jmp_bits, 2'b00);
        rsp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        rsp_en = 1'b1;
        tick();
        chk("t6_idle", req_s, 1'b0);
        tick();
        chk("t6_first_req", req_s, 1'b1);
        chk("t6_first_addr", addr_s, 32'h0);
        repeat (4) tick();
        chk("t6_no_flush", nfl, 2);
        chk("t6_refill", nwr, 11);
        chk("wr_flush_excl", both, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
